// File: rtl/serdes_deser_rx.sv
// serdes_deser_rx: strobed serial-to-parallel receiver.
// A frame is one start bit (0), DATA_W payload bits sent LSB first, an
// optional parity bit and one stop bit (1). Each bit occupies one ser_en
// strobe. Good frames are handed to the consumer with a valid/ack handshake.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   ser_in       : serial line (idle high), sampled only when ser_en=1
//   ser_en       : bit strobe
//   par_en       : parity bit present (latched at the start bit)
//   data_ack     : consumer acknowledge of the held word
//   data_out     : last good payload word
//   data_valid   : data_out holds an unacknowledged word
//   parity_err   : parity status of the word in data_out
//   frame_err    : one-cycle pulse on a stop bit sampled as 0
//   overrun      : sticky, an unacknowledged word was overwritten
//   busy         : receiver FSM is not idle
module serdes_deser_rx #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ser_in,
    input  logic              ser_en,
    input  logic              par_en,
    input  logic              data_ack,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
    localparam logic        P_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    w_bit_cnt_nxt;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic                r_par_lat;
    logic                w_par_lat_nxt;
    logic                r_par_flag;
    logic                w_par_flag_nxt;
    // A good stop bit arms a one-cycle-delayed load of the output word.
    logic                r_load;
    logic                w_load_nxt;
    logic                r_pend_perr;
    logic                w_pend_perr_nxt;

    logic [DATA_W-1:0]   r_data_out;
    logic [DATA_W-1:0]   w_data_out_nxt;
    logic                r_data_valid;
    logic                w_data_valid_nxt;
    logic                r_parity_err;
    logic                w_parity_err_nxt;
    logic                r_frame_err;
    logic                w_frame_err_nxt;
    logic                r_overrun;
    logic                w_overrun_nxt;
    logic                r_busy;
    logic                w_busy_nxt;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_lat    <= 1'b0;
            r_par_flag   <= 1'b0;
            r_load       <= 1'b0;
            r_pend_perr  <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_par_lat    <= w_par_lat_nxt;
            r_par_flag   <= w_par_flag_nxt;
            r_load       <= w_load_nxt;
            r_pend_perr  <= w_pend_perr_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_parity_err <= w_parity_err_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_overrun    <= w_overrun_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Next-state and frame assembly; everything holds without a strobe.
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_par_lat_nxt   = r_par_lat;
        w_par_flag_nxt  = r_par_flag;
        w_load_nxt      = 1'b0;
        w_pend_perr_nxt = r_pend_perr;
        w_frame_err_nxt = 1'b0;

        if (ser_en) begin
            case (r_state)
                IDLE: begin
                    if (!ser_in) begin
                        w_state_nxt    = DATA;
                        w_bit_cnt_nxt  = '0;
                        w_par_lat_nxt  = par_en;
                        w_par_flag_nxt = 1'b0;
                    end
                end
                DATA: begin
                    // LSB-first: each new bit enters at the MSB and moves down.
                    w_shift_nxt   = {ser_in, r_shift[DATA_W-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                        w_state_nxt = r_par_lat ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    w_par_flag_nxt = ((^r_shift) ^ ser_in) != P_ODD;
                    w_state_nxt    = STOP;
                end
                STOP: begin
                    if (ser_in) begin
                        w_load_nxt      = 1'b1;
                        w_pend_perr_nxt = r_par_lat & r_par_flag;
                        w_state_nxt     = IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = BREAK;
                    end
                end
                BREAK: begin
                    if (ser_in) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // Output word and consumer handshake.
    always_comb begin
        w_data_out_nxt   = r_data_out;
        w_data_valid_nxt = r_data_valid;
        w_parity_err_nxt = r_parity_err;
        w_overrun_nxt    = r_overrun;

        if (r_load) begin
            // Shift register is untouched in IDLE, so it still holds the payload.
            w_data_out_nxt   = r_shift;
            w_data_valid_nxt = 1'b1;
            w_parity_err_nxt = r_pend_perr;
            w_overrun_nxt    = r_data_valid & ~data_ack;
        end else if (data_ack && r_data_valid) begin
            w_data_valid_nxt = 1'b0;
            w_overrun_nxt    = 1'b0;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule
